// File: rtl/pn_pkg.sv
// Shared types, target codes and address-field helpers for the pn_dispatch command path.
package pn_pkg;

  localparam logic [1:0] TGT_RC   = 2'b00;
  localparam logic [1:0] TGT_SYN  = 2'b01;
  localparam logic [1:0] TGT_SOMA = 2'b10;
  localparam logic [1:0] TGT_STDP = 2'b11;

  typedef enum logic {StIdle = 1'b0, StExpand = 1'b1} state_e;

  // Helpers work on a widest-case address and take the neuron-ID width as an argument.
  localparam int unsigned MaxNidW  = 16;
  localparam int unsigned MaxAddrW = 2 * MaxNidW + 2;

  typedef logic [MaxAddrW-1:0] addr_t;
  typedef logic [MaxNidW-1:0]  nid_t;

  function automatic nid_t pn_nid_mask(int unsigned nid_w);
    return nid_t'((64'd1 << nid_w) - 64'd1);
  endfunction

  function automatic logic pn_field_rc(addr_t addr, int unsigned nid_w);
    return addr[2*nid_w+1];
  endfunction

  function automatic logic pn_field_cfg(addr_t addr, int unsigned nid_w);
    return addr[2*nid_w];
  endfunction

  function automatic logic [1:0] pn_field_tgt(addr_t addr, int unsigned nid_w);
    return 2'(addr >> (2 * nid_w - 2));
  endfunction

  function automatic nid_t pn_field_nb(addr_t addr, int unsigned nid_w);
    return nid_t'(addr >> nid_w) & pn_nid_mask(nid_w);
  endfunction

  function automatic nid_t pn_field_na(addr_t addr, int unsigned nid_w);
    return nid_t'(addr) & pn_nid_mask(nid_w);
  endfunction

endpackage

// File: rtl/pn_dispatch_if.sv
// Command, weight-update and strobe bundle between a command source and pn_dispatch.
interface pn_dispatch_if #(
  parameter int unsigned NID_W  = 7,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WGT_W  = 8
);
  localparam int unsigned ADDR_W = 2 * NID_W + 2;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;

  logic              swu_valid;
  logic              swu_ready;
  logic [NID_W-1:0]  swu_addr;
  logic [WGT_W-1:0]  swu_data;

  logic              syn_we;
  logic              syn_rd;
  logic              syn_rc;
  logic [NID_W-1:0]  syn_addr;
  logic [DATA_W-1:0] syn_wdata;
  logic              soma_we;
  logic [DATA_W-1:0] soma_wdata;
  logic              stdp_we;
  logic [NID_W-1:0]  stdp_addr;
  logic [DATA_W-1:0] stdp_wdata;
  logic              busy;

  modport master (
    output in_valid, in_addr, in_data, swu_valid, swu_addr, swu_data,
    input  in_ready, swu_ready, syn_we, syn_rd, syn_rc, syn_addr, syn_wdata,
           soma_we, soma_wdata, stdp_we, stdp_addr, stdp_wdata, busy
  );

  modport slave (
    input  in_valid, in_addr, in_data, swu_valid, swu_addr, swu_data,
    output in_ready, swu_ready, syn_we, syn_rd, syn_rc, syn_addr, syn_wdata,
           soma_we, soma_wdata, stdp_we, stdp_addr, stdp_wdata, busy
  );

endinterface

// File: rtl/pn_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit to separate full from empty.
module pn_cmd_fifo #(
  parameter int unsigned Width = 48,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW   = $clog2(Depth);
  localparam int unsigned PtrW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Full blocks the push even if a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pn_dispatch.sv
// Neuron-core command dispatcher: FIFO-buffered decode into synapse/soma/STDP strobes.
// Define PN_DISPATCH_SWU_EN to merge STDP weight-update writes in with priority over commands.
module pn_dispatch
  import pn_pkg::*;
#(
  parameter int unsigned NID_W      = 7,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WGT_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic         clk_i,
  input logic         rst_ni,
  pn_dispatch_if.slave bus
);

  localparam int unsigned ADDR_W = 2 * NID_W + 2;

  logic [ADDR_W+DATA_W-1:0] fifo_rdata;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;
  logic                     fifo_full, fifo_empty;
  logic                     in_ready, push, pop;
  logic                     swu_pend;

  addr_t            head_x;
  logic             f_rc, f_cfg;
  logic [1:0]       f_tgt;
  logic [NID_W-1:0] f_na, f_nb;

  state_e            state_q, state_d;
  logic [NID_W-1:0]  nb_q, nb_d;
  logic              ready_q;
  logic              busy_q, busy_d;
  logic              swu_ready_q, swu_ready_d;
  logic              syn_we_q, syn_we_d, syn_rd_q, syn_rd_d, syn_rc_q, syn_rc_d;
  logic [NID_W-1:0]  syn_addr_q, syn_addr_d;
  logic [DATA_W-1:0] syn_wdata_q, syn_wdata_d;
  logic              soma_we_q, soma_we_d;
  logic [DATA_W-1:0] soma_wdata_q, soma_wdata_d;
  logic              stdp_we_q, stdp_we_d;
  logic [NID_W-1:0]  stdp_addr_q, stdp_addr_d;
  logic [DATA_W-1:0] stdp_wdata_q, stdp_wdata_d;

  // ready_q holds in_ready low throughout reset and for the releasing edge.
  assign in_ready = ready_q && !fifo_full;
  assign push     = bus.in_valid && in_ready;

  pn_cmd_fifo #(
    .Width (ADDR_W + DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i ({bus.in_addr, bus.in_data}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {head_addr, head_data} = fifo_rdata;
  assign head_x = addr_t'(head_addr);
  assign f_rc   = pn_field_rc(head_x, NID_W);
  assign f_cfg  = pn_field_cfg(head_x, NID_W);
  assign f_tgt  = pn_field_tgt(head_x, NID_W);
  assign f_na   = NID_W'(pn_field_na(head_x, NID_W));
  assign f_nb   = NID_W'(pn_field_nb(head_x, NID_W));

`ifdef PN_DISPATCH_SWU_EN
  assign swu_pend = bus.swu_valid;
`else
  logic unused_swu;
  assign swu_pend   = 1'b0;
  assign unused_swu = ^{bus.swu_valid, bus.swu_addr, bus.swu_data};
`endif

  always_comb begin
    state_d      = state_q;
    nb_d         = nb_q;
    pop          = 1'b0;
    swu_ready_d  = 1'b0;
    syn_we_d     = 1'b0;
    syn_rd_d     = 1'b0;
    syn_rc_d     = 1'b0;
    syn_addr_d   = '0;
    syn_wdata_d  = '0;
    soma_we_d    = 1'b0;
    soma_wdata_d = '0;
    stdp_we_d    = 1'b0;
    stdp_addr_d  = '0;
    stdp_wdata_d = '0;
    busy_d       = !fifo_empty || (state_q != StIdle);

    case (state_q)
      StExpand: begin
        syn_rd_d   = 1'b1;
        syn_addr_d = nb_q;
        nb_d       = '0;
        state_d    = StIdle;
      end
      default: begin
        if (swu_pend) begin
          syn_we_d    = 1'b1;
          syn_addr_d  = bus.swu_addr;
          syn_wdata_d = DATA_W'(bus.swu_data);
          swu_ready_d = 1'b1;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          if (f_cfg) begin
            unique case (f_tgt)
              TGT_RC: begin
                syn_we_d    = 1'b1;
                syn_rc_d    = 1'b1;
                syn_addr_d  = f_na;
                syn_wdata_d = head_data;
              end
              TGT_SYN: begin
                syn_we_d    = 1'b1;
                syn_addr_d  = f_na;
                syn_wdata_d = head_data;
              end
              TGT_SOMA: begin
                soma_we_d    = 1'b1;
                soma_wdata_d = head_data;
              end
              TGT_STDP: begin
                stdp_we_d    = 1'b1;
                stdp_addr_d  = f_na;
                stdp_wdata_d = head_data;
              end
            endcase
          end else begin
            syn_rd_d   = 1'b1;
            syn_rc_d   = f_rc;
            syn_addr_d = f_na;
            if (!f_rc && (f_nb != '0)) begin
              nb_d    = f_nb;
              state_d = StExpand;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      nb_q         <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      swu_ready_q  <= 1'b0;
      syn_we_q     <= 1'b0;
      syn_rd_q     <= 1'b0;
      syn_rc_q     <= 1'b0;
      syn_addr_q   <= '0;
      syn_wdata_q  <= '0;
      soma_we_q    <= 1'b0;
      soma_wdata_q <= '0;
      stdp_we_q    <= 1'b0;
      stdp_addr_q  <= '0;
      stdp_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      nb_q         <= nb_d;
      ready_q      <= 1'b1;
      busy_q       <= busy_d;
      swu_ready_q  <= swu_ready_d;
      syn_we_q     <= syn_we_d;
      syn_rd_q     <= syn_rd_d;
      syn_rc_q     <= syn_rc_d;
      syn_addr_q   <= syn_addr_d;
      syn_wdata_q  <= syn_wdata_d;
      soma_we_q    <= soma_we_d;
      soma_wdata_q <= soma_wdata_d;
      stdp_we_q    <= stdp_we_d;
      stdp_addr_q  <= stdp_addr_d;
      stdp_wdata_q <= stdp_wdata_d;
    end
  end

  assign bus.in_ready   = in_ready;
`ifdef PN_DISPATCH_SWU_EN
  assign bus.swu_ready  = swu_ready_q;
`else
  assign bus.swu_ready  = 1'b0;
`endif
  assign bus.syn_we     = syn_we_q;
  assign bus.syn_rd     = syn_rd_q;
  assign bus.syn_rc     = syn_rc_q;
  assign bus.syn_addr   = syn_addr_q;
  assign bus.syn_wdata  = syn_wdata_q;
  assign bus.soma_we    = soma_we_q;
  assign bus.soma_wdata = soma_wdata_q;
  assign bus.stdp_we    = stdp_we_q;
  assign bus.stdp_addr  = stdp_addr_q;
  assign bus.stdp_wdata = stdp_wdata_q;
  // Registered so busy stays high across the cycles in which the strobes are visible.
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_pn_dispatch.sv
// Bench for pn_dispatch: directed scenarios plus random traffic against a queue-based model.
module tb_pn_dispatch;

  localparam int unsigned Depth = 4;
`ifdef PN_DISPATCH_SWU_EN
  localparam bit SwuOn = 1'b1;
`else
  localparam bit SwuOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pn_dispatch_if #(.NID_W(7), .DATA_W(32), .WGT_W(8)) bus ();

  pn_dispatch #(
    .NID_W      (7),
    .DATA_W     (32),
    .WGT_W      (8),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending commands, a pending second spike, and the input-ready flag.
  logic [15:0] mq_a[$];
  logic [31:0] mq_d[$];
  bit          m_exp   = 1'b0;
  logic [31:0] m_nb    = '0;
  bit          m_ready = 1'b0;

  logic [31:0] e_syn_we, e_syn_rd, e_syn_rc, e_syn_addr, e_syn_wdata;
  logic [31:0] e_soma_we, e_soma_wdata, e_stdp_we, e_stdp_addr, e_stdp_wdata;
  logic [31:0] e_swu_ready, e_busy, e_in_ready;

  bit saw_full;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("syn_we", 32'(bus.syn_we), e_syn_we);
    chk("syn_rd", 32'(bus.syn_rd), e_syn_rd);
    chk("syn_rc", 32'(bus.syn_rc), e_syn_rc);
    chk("syn_addr", 32'(bus.syn_addr), e_syn_addr);
    chk("syn_wdata", bus.syn_wdata, e_syn_wdata);
    chk("soma_we", 32'(bus.soma_we), e_soma_we);
    chk("soma_wdata", bus.soma_wdata, e_soma_wdata);
    chk("stdp_we", 32'(bus.stdp_we), e_stdp_we);
    chk("stdp_addr", 32'(bus.stdp_addr), e_stdp_addr);
    chk("stdp_wdata", bus.stdp_wdata, e_stdp_wdata);
    chk("swu_ready", 32'(bus.swu_ready), e_swu_ready);
    chk("busy", 32'(bus.busy), e_busy);
    chk("in_ready", 32'(bus.in_ready), e_in_ready);
  endtask

  // Advance one clock: predict from pre-edge inputs, then compare just after the edge.
  task automatic tick(output bit acc);
    bit          rdy_now;
    logic [31:0] a, d, na, nb, tgt;
    rdy_now = m_ready && (mq_a.size() < Depth);
    acc = rst_n && bus.in_valid && rdy_now;
    e_syn_we = 0; e_syn_rd = 0; e_syn_rc = 0; e_syn_addr = 0; e_syn_wdata = 0;
    e_soma_we = 0; e_soma_wdata = 0; e_stdp_we = 0; e_stdp_addr = 0; e_stdp_wdata = 0;
    e_swu_ready = 0; e_busy = 0;
    if (!rst_n) begin
      mq_a.delete();
      mq_d.delete();
      m_exp   = 1'b0;
      m_ready = 1'b0;
    end else begin
      e_busy = 32'((mq_a.size() != 0) || m_exp);
      if (m_exp) begin
        e_syn_rd   = 1;
        e_syn_addr = m_nb;
        m_exp      = 1'b0;
      end else if (SwuOn && bus.swu_valid) begin
        e_syn_we    = 1;
        e_syn_addr  = 32'(bus.swu_addr);
        e_syn_wdata = 32'(bus.swu_data);
        e_swu_ready = 1;
      end else if (mq_a.size() != 0) begin
        a   = 32'(mq_a.pop_front());
        d   = mq_d.pop_front();
        na  = a % 128;
        nb  = (a / 128) % 128;
        tgt = (a / 4096) % 4;
        if ((a / 16384) % 2 == 1) begin
          if (tgt == 2) begin
            e_soma_we = 1; e_soma_wdata = d;
          end else if (tgt == 3) begin
            e_stdp_we = 1; e_stdp_addr = na; e_stdp_wdata = d;
          end else begin
            e_syn_we = 1; e_syn_addr = na; e_syn_wdata = d; e_syn_rc = 32'(tgt == 0);
          end
        end else begin
          e_syn_rd   = 1;
          e_syn_addr = na;
          e_syn_rc   = (a / 32768) % 2;
          if (e_syn_rc == 0 && nb != 0) begin
            m_exp = 1'b1;
            m_nb  = nb;
          end
        end
      end
      if (acc) begin
        mq_a.push_back(bus.in_addr);
        mq_d.push_back(bus.in_data);
      end
      m_ready = 1'b1;
    end
    e_in_ready = 32'(m_ready && (mq_a.size() < Depth));
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send(input logic [15:0] addr, input logic [31:0] data);
    bit acc;
    bus.in_valid = 1'b1;
    bus.in_addr  = addr;
    bus.in_data  = data;
    for (int k = 0; k < 40; k++) begin
      if (!bus.in_ready) saw_full = 1'b1;
      tick(acc);
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    bit acc;
    for (int k = 0; k < n; k++) tick(acc);
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 60; k++) begin
      if (!bus.busy && mq_a.size() == 0 && !m_exp) break;
      tick(acc);
    end
    chk("drain_busy", 32'(bus.busy), 0);
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom);
    if ($urandom_range(0, 3) == 0) a[13:7] = '0;
    return a;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bus.in_valid  = 1'b0;
    bus.in_addr   = '0;
    bus.in_data   = '0;
    bus.swu_valid = 1'b0;
    bus.swu_addr  = '0;
    bus.swu_data  = '0;
    saw_full      = 1'b0;

    // Reset, then release.
    rst_n = 1'b0;
    idle_ticks(3);
    chk("reset_in_ready", 32'(bus.in_ready), 0);
    rst_n = 1'b1;
    idle_ticks(1);
    chk("release_in_ready", 32'(bus.in_ready), 1);

    // SYN configuration write: strobe two edges after the accept.
    send(16'h5003, 32'hA5);
    idle_ticks(1);
    chk("cfg_syn_we", 32'(bus.syn_we), 1);
    chk("cfg_syn_addr", 32'(bus.syn_addr), 3);
    chk("cfg_syn_wdata", bus.syn_wdata, 32'hA5);
    drain();

    // Two-neuron spike NA=5, NB=5.
    send(16'h0285, 32'h0);
    idle_ticks(1);
    chk("spk2_first_rd", 32'(bus.syn_rd), 1);
    idle_ticks(1);
    chk("spk2_second_rd", 32'(bus.syn_rd), 1);
    chk("spk2_second_addr", 32'(bus.syn_addr), 5);
    idle_ticks(1);
    chk("spk2_busy_after", 32'(bus.busy), 0);

    // Rich-club spike.
    send(16'h8012, 32'h0);
    idle_ticks(1);
    chk("rc_spike_rc", 32'(bus.syn_rc), 1);
    chk("rc_spike_addr", 32'(bus.syn_addr), 32'h12);
    drain();

    // Continuous two-neuron spikes outpace the drain and fill the FIFO.
    saw_full = 1'b0;
    for (int i = 0; i < 10; i++) send({2'b00, 7'(i + 1), 7'(i + 20)}, 32'(i));
    chk("fifo_filled", 32'(saw_full), 1);
    drain();

    // Weight update requested while a spike expansion is in progress.
    send(16'h0285, 32'h0);
    idle_ticks(1);
    bus.swu_valid = 1'b1;
    bus.swu_addr  = 7'h09;
    bus.swu_data  = 8'h3C;
    idle_ticks(1);
    chk("swu_nb_strobe", 32'(bus.syn_rd), 1);
    idle_ticks(1);
`ifdef PN_DISPATCH_SWU_EN
    chk("swu_we", 32'(bus.syn_we), 1);
    chk("swu_wdata", bus.syn_wdata, 32'h0000003C);
    chk("swu_ready_hi", 32'(bus.swu_ready), 1);
`else
    idle_ticks(2);
    chk("swu_ready_tied", 32'(bus.swu_ready), 0);
`endif
    bus.swu_valid = 1'b0;
    drain();

    // Reset while expanding with three commands queued.
    for (int i = 0; i < 6; i++) send({2'b00, 7'(i + 1), 7'(i + 40)}, 32'(i));
    rst_n = 1'b0;
    idle_ticks(1);
    chk("rst_mid_no_nb", 32'(bus.syn_rd), 0);
    idle_ticks(1);
    rst_n = 1'b1;
    idle_ticks(1);
    chk("rst_mid_busy", 32'(bus.busy), 0);
    chk("rst_mid_ready", 32'(bus.in_ready), 1);
    idle_ticks(2);
    chk("rst_mid_flushed", 32'(bus.syn_rd | bus.syn_we | bus.busy), 0);

    // Random traffic.
    acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_addr  = rand_addr();
        bus.in_data  = $urandom;
      end
      bus.swu_valid = ($urandom_range(0, 9) == 0);
      bus.swu_addr  = 7'($urandom);
      bus.swu_data  = 8'($urandom);
      tick(acc);
    end
    bus.in_valid  = 1'b0;
    bus.swu_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pn_dispatch.md
# pn_dispatch

Parametrised command dispatcher for one neuron core. It accepts 16-bit-class address/data commands over a valid/ready handshake and buffers them in a small FIFO. It decodes each command into single-cycle write or read strobes towards the synapse, soma and STDP blocks. Two-neuron spike packets are expanded into back-to-back synapse reads. Optionally, STDP synaptic-weight-update (SWU) writes are merged in with priority.

## Interface
Parameters:
- NID_W, 7: neuron-ID width.
- ADDR_W, 2*NID_W+2: command address width (derived, not overridable).
- DATA_W, 32: command data width.
- WGT_W, 8: SWU weight width; must be ≤ DATA_W.
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥ 2.

Ports:
- clk, in, 1: single clock; all logic is on its rising edge.
- rst, in, 1: synchronous, active-low reset.
- in_valid, in, 1: command valid.
- in_ready, out, 1: FIFO not full.
- in_addr, in, ADDR_W: command address.
- in_data, in, DATA_W: command data.
- swu_valid, in, 1: weight-update request.
- swu_ready, out, 1: weight update issued this cycle.
- swu_addr, in, NID_W: target synapse address for the weight update.
- swu_data, in, WGT_W: new weight.
- syn_we, out, 1: synapse write strobe.
- syn_rd, out, 1: synapse read (spike) strobe.
- syn_rc, out, 1: rich-club qualifier, valid alongside syn_we or syn_rd.
- syn_addr, out, NID_W: synapse address.
- syn_wdata, out, DATA_W: synapse write data.
- soma_we, out, 1: soma write strobe.
- soma_wdata, out, DATA_W: soma write data.
- stdp_we, out, 1: STDP write strobe.
- stdp_addr, out, NID_W: STDP address.
- stdp_wdata, out, DATA_W: STDP write data.
- busy, out, 1: FIFO non-empty or state ≠ IDLE.

## Operation
Address fields (N = NID_W):
- RC = in_addr[2N+1].
- CFG = in_addr[2N].
- TGT = in_addr[2N-1:2N-2].
- NB = in_addr[2N-1:N].
- NA = in_addr[N-1:0].

Decode when CFG = 1 (configuration write):
- TGT 01: syn_we, syn_addr = NA, syn_wdata = data.
- TGT 10: soma_we, soma_wdata = data.
- TGT 11: stdp_we, stdp_addr = NA, stdp_wdata = data.
- TGT 00: syn_we with syn_rc = 1, syn_addr = NA, syn_wdata = data (rich-club weight write).

Decode when CFG = 0 (spike):
- RC = 1: one syn_rd with syn_rc = 1, addr = NA.
- RC = 0, NB = 0: one syn_rd, addr = NA.
- RC = 0, NB ≠ 0: syn_rd addr = NA, then syn_rd addr = NB on the next cycle.

FSM states are IDLE and EXPAND:
- IDLE, SWU pending (see Configuration): issue syn_we with syn_addr = swu_addr and syn_wdata = zero-extended swu_data; pulse swu_ready. Stay in IDLE.
- IDLE, no SWU, FIFO non-empty: pop the head and issue its decode. A two-neuron spike latches NB and moves to EXPAND.
- EXPAND: issue syn_rd at the latched NB and return to IDLE. SWU and FIFO pops are blocked in this state; an expansion is never split.

Other rules:
- Every strobe is a one-cycle pulse. At most one strobe group (syn / soma / stdp) is active per cycle.
- Addr/data outputs of any group whose strobe is low are driven to 0.
- SWU has fixed priority over the FIFO. Continuous swu_valid starves commands; this is accepted and documented.
- FIFO push and pop in the same cycle is legal when full: in_ready stays 0 that cycle and the pop frees a slot for the next cycle.

## Timing
- Reset (rst = 0 at an edge): all outputs 0, FIFO flushed, state IDLE, any latched NB discarded. in_ready = 0 during reset and goes to 1 in the first cycle after release.
- Command accepted at edge t, with the FIFO empty and the FSM idle: the strobe is visible after edge t+1 (2-cycle latency).
- Two-neuron expansion: NA strobe after edge t+1, NB strobe after edge t+2.
- SWU with swu_valid high before edge t and the FSM in IDLE: syn_we and swu_ready are both visible after edge t.
- Sustained throughput is one strobe per cycle. A two-neuron spike occupies two cycles.

## Configuration
Macro PN_DISPATCH_SWU_EN:
- Defined: SWU arbitration as described in Operation.
- Undefined: swu_* inputs are ignored, swu_ready is tied to 0, and the FSM never issues SWU writes.

## Structure
- Package pn_pkg holds:
  - TGT codes TGT_RC = 2'b00, TGT_SYN = 2'b01, TGT_SOMA = 2'b10, TGT_STDP = 2'b11.
  - The FSM state enum (IDLE, EXPAND).
  - Field-slicing helper functions parametrised by NID_W.
- Sub-module pn_cmd_fifo: synchronous FIFO, width ADDR_W+DATA_W, depth FIFO_DEPTH, with full/empty flags and wrap-around pointers using an extra MSB.

## Test plan
- Reset release, then config write addr 0x5003 (SYN, NA = 3), data 0xA5 → after 2 cycles: syn_we = 1, syn_addr = 3, syn_wdata = 0xA5; soma_we = stdp_we = 0.
- Spike addr 0x0285 (NB = 5, NA = 5) → syn_rd at addr 5 for two consecutive cycles; busy high throughout and low in the following cycle.
- Spike addr 0x8012 (RC = 1) → one syn_rd with syn_rc = 1, addr 0x12.
- 5 back-to-back commands with FIFO_DEPTH = 4 and no pops possible → in_ready falls after the 4th accept; the 5th command is issued in order after draining.
- With PN_DISPATCH_SWU_EN: swu_valid during an EXPAND → SWU write issued immediately after the NB strobe, with swu_data 0x3C giving syn_wdata = 0x0000003C. Without the macro → swu_ready stays 0.
- rst asserted mid-EXPAND with 3 entries queued → no NB strobe, FIFO empty, busy = 0 after release.
